// File: rtl/store_buffer_drainer_pkg.sv
// Shared types for the store buffer drainer and the blocks around it.
package store_buffer_drainer_pkg;

  typedef enum logic [1:0] {
    CACHE_ACCESS_SIZE_BYTE = 2'd0,
    CACHE_ACCESS_SIZE_HALF = 2'd1,
    CACHE_ACCESS_SIZE_WORD = 2'd2
  } cache_access_size_t;

endpackage

// File: rtl/store_buffer_drainer_if.sv
// Data cache write request port: request handshake plus completion strobe.
interface store_buffer_drainer_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32
);
  localparam int LANES = WORD_SIZE / 8;

  logic                 valid;
  logic                 ready;
  logic [ADDR_SIZE-1:0] addr;
  logic [WORD_SIZE-1:0] data;
  logic [LANES-1:0]     strb;
  logic                 done;

  modport master (output valid, addr, data, strb, input ready, done);
  modport slave  (input valid, addr, data, strb, output ready, done);
endinterface

// File: rtl/store_buffer_drainer.sv
// Store buffer drainer: moves the oldest committed store into the dcache write
// port, one entry at a time, and pops the buffer only after the cache reports
// completion. Misaligned entries are dropped without touching the cache.
module store_buffer_drainer
  import store_buffer_drainer_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int WORD_SIZE  = 32,
  parameter int COUNT_BITS = 32
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     sb_empty_i,
  input  logic                     sb_full_i,
  input  logic [ADDR_SIZE-1:0]     sb_addr_i,
  input  logic [WORD_SIZE-1:0]     sb_data_i,
  input  cache_access_size_t       sb_size_i,
  output logic                     sb_get_enable_o,
  output logic                     sb_hit_o,
  input  logic                     load_pending_i,
  input  logic                     drain_i,
  store_buffer_drainer_if.master   dc_wr,
  output logic                     misaligned_o,
  output logic                     idle_o,
  output logic [COUNT_BITS-1:0]    retired_count_o
);

  localparam int LANES    = WORD_SIZE / 8;
  localparam int OFF_BITS = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    POP   = 2'd3
  } state_t;

  state_t                 state_q;
  state_t                 state_d;

  logic [ADDR_SIZE-1:0]   addr_q;
  logic [WORD_SIZE-1:0]   data_q;
  logic [LANES-1:0]       strb_q;
  logic                   drop_q;
  logic [COUNT_BITS-1:0]  count_q;

  logic [OFF_BITS-1:0]    off;
  logic [ADDR_SIZE-1:0]   fmt_addr;
  logic [WORD_SIZE-1:0]   fmt_data;
  logic [LANES-1:0]       fmt_strb;
  logic                   fmt_misaligned;
  logic                   start;

  assign off = sb_addr_i[OFF_BITS-1:0];

  // Loads own the dcache port unless the buffer is full or a drain is forced.
  assign start = !sb_empty_i && (!load_pending_i || sb_full_i || drain_i);

  // Lane formatting of the head entry; the formatted form is what gets latched.
  always_comb begin
    fmt_addr       = {sb_addr_i[ADDR_SIZE-1:OFF_BITS], {OFF_BITS{1'b0}}};
    fmt_data       = sb_data_i;
    fmt_strb       = '1;
    fmt_misaligned = 1'b0;
    case (sb_size_i)
      CACHE_ACCESS_SIZE_BYTE: begin
        fmt_strb = LANES'(1) << off;
        fmt_data = {LANES{sb_data_i[7:0]}};
      end
      CACHE_ACCESS_SIZE_HALF: begin
        fmt_strb       = LANES'(3) << off;
        fmt_data       = {(LANES/2){sb_data_i[15:0]}};
        fmt_misaligned = off[0];
      end
      default: begin
        fmt_misaligned = (off != '0);
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; once out of IDLE the entry is committed regardless of loads.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = fmt_misaligned ? POP : ISSUE;
        end
      end
      ISSUE: begin
        if (dc_wr.ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (dc_wr.done) begin
          state_d = POP;
        end
      end
      POP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture the formatted request on the start decision so it stays stable.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_q <= '0;
      data_q <= '0;
      strb_q <= '0;
      drop_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      addr_q <= fmt_addr;
      data_q <= fmt_data;
      strb_q <= fmt_strb;
      drop_q <= fmt_misaligned;
    end
  end

  // Retired-store counter: bumps on every pop that was really written.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q <= '0;
    end else if (state_q == POP && !drop_q) begin
      count_q <= count_q + COUNT_BITS'(1);
    end
  end

  assign dc_wr.valid     = (state_q == ISSUE);
  assign dc_wr.addr      = addr_q;
  assign dc_wr.data      = data_q;
  assign dc_wr.strb      = strb_q;
  assign sb_get_enable_o = (state_q == POP);
  assign sb_hit_o        = (state_q == POP);
  assign misaligned_o    = (state_q == POP) && drop_q;
  assign idle_o          = (state_q == IDLE) && sb_empty_i;
  assign retired_count_o = count_q;

endmodule
